pkt_tx_scheduler: RTL and testbench
===================================

// Module: pkt_tx_scheduler
// PURPOSE
//   Shares the single ipv6_packetiser between N_SRC sensor byte sources. Round-robin
//   arbitration picks one pending byte and issues it as a one-cycle data_valid pulse.
//   The block then tracks the packetiser's packet_valid window and enforces an idle gap
//   before the next issue. A start timeout keeps a silent packetiser from stalling the node.
// PARAMETERS
//   N_SRC          4   number of requesting sources (2..8)
//   START_TIMEOUT  16  cycles to wait for pkt_active to rise after issue (>=1)
//   GAP_CYCLES     2   idle cycles between pkt_active fall and next grant (0 = none)
// PORTS
//   clk             in   1          system clock, rising edge
//   rst_n           in   1          async active-low reset
//   enable          in   1          1 = new grants allowed; in-flight packet always completes
//   src_req         in   N_SRC      level request per source; hold until matching src_ack
//   src_data        in   8*N_SRC    byte of source i on [8i+7:8i], stable while src_req[i]=1
//   src_ack         out  N_SRC      one-cycle pulse: source's byte taken; one-hot or zero
//   pkt_data        out  8          to packetiser data_in; holds last issued byte
//   pkt_data_valid  out  1          to packetiser data_valid; one-cycle pulse per grant
//   pkt_active      in   1          from packetiser packet_valid
//   busy            out  1          1 whenever state != IDLE
//   cur_src         out  $clog2(N_SRC)  index of last granted source
//   timeout_err     out  1          one-cycle pulse on start timeout
//   drop_count      out  8          saturating count of start timeouts
// BEHAVIOUR
//   Reset (async, rst_n=0): all outputs 0, state=IDLE, counters 0, rr_ptr=N_SRC-1.
//   All outputs registered. States: IDLE, WAIT_START, WAIT_DONE, GAP.
//   IDLE: if enable && |src_req at edge k: winner = first set req searching rr_ptr+1,
//     rr_ptr+2 ... modulo N_SRC. At edge k: src_ack[winner]<=1, pkt_data<=src_data[winner],
//     pkt_data_valid<=1, cur_src<=winner, rr_ptr<=winner, wait_cnt<=0, ->WAIT_START.
//     Latency: request seen at edge k -> ack/valid high for exactly the cycle after k.
//   WAIT_START: src_ack/pkt_data_valid back to 0. Each cycle: if pkt_active=1 -> WAIT_DONE;
//     else wait_cnt++; when wait_cnt reaches START_TIMEOUT-1 with pkt_active still 0:
//     timeout_err pulse, drop_count+1 (sticks at 255), ->GAP. pkt_active wins if it rises
//     on the timeout cycle.
//   WAIT_DONE: stay while pkt_active=1; on pkt_active=0 -> GAP (GAP_CYCLES=0: ->IDLE).
//     No timeout here; packet length is owned by the packetiser.
//   GAP: count GAP_CYCLES cycles, then ->IDLE. Reqs in GAP are ignored, not lost.
//   enable only gates the IDLE grant; deasserting it mid-packet does not abort.
//   A source that keeps src_req high after ack is re-eligible; round-robin guarantees
//     every other pending source is served before it repeats.
//   src_req dropped before ack: withdrawn, no ack, no issue.
//   Reset mid-packet: immediate return to reset values; packetiser reset is its own concern.
//   pkt_data not cleared after issue; qualify only with pkt_data_valid.
// TESTING
//   1 Only src_req[2]=1, byte 0xAB -> next cycle src_ack=4'b0100, pkt_data_valid=1,
//     pkt_data=0xAB, cur_src=2; busy until GAP_CYCLES after pkt_active falls.
//   2 All four reqs at once, bytes 0x10..0x13 -> issues 0x10,0x11,0x12,0x13 in order, each
//     GAP_CYCLES+1 cycles after previous pkt_active fall; exactly one ack pulse per source.
//   3 Issue with pkt_active held 0 -> timeout_err pulse 16 cycles after valid pulse,
//     drop_count=1, next pending source served after gap.
//   4 enable=0 with src_req=4'b1111 -> no ack/valid for 50 cycles; enable=0 during
//     WAIT_DONE -> packet completes, busy falls, no further grant.
//   5 rst_n=0 during WAIT_DONE -> all outputs 0 asynchronously; after release with all
//     reqs set, source 0 is granted first.
//   6 300 consecutive start timeouts -> drop_count saturates at 255, no wrap.

Source files
------------

// File: rtl/pkt_tx_if.sv
// Byte-source request/ack bus and packetiser data path shared by pkt_tx_scheduler.
// The master modport is the scheduler side. The slave modport is the sources and packetiser side.
interface pkt_tx_if #(
  parameter int N_SRC = 4
) ();
  logic [N_SRC-1:0]   src_req;
  logic [8*N_SRC-1:0] src_data;
  logic [N_SRC-1:0]   src_ack;
  logic [7:0]         pkt_data;
  logic               pkt_data_valid;
  logic               pkt_active;

  modport master (
    input  src_req, src_data, pkt_active,
    output src_ack, pkt_data, pkt_data_valid
  );

  modport slave (
    output src_req, src_data, pkt_active,
    input  src_ack, pkt_data, pkt_data_valid
  );
endinterface

// File: rtl/pkt_tx_scheduler.sv
// Round-robin scheduler that shares one packetiser between N_SRC byte sources.
// It enforces a start timeout and an idle gap between packets.
//
// state      | meaning
// IDLE       | waiting for enable and a pending request; grants on the same edge
// WAIT_START | byte issued, waiting for pkt_active to rise (start timeout armed)
// WAIT_DONE  | packetiser busy, waiting for pkt_active to fall
// GAP        | enforced idle cycles before the next grant
module pkt_tx_scheduler #(
  parameter int N_SRC         = 4,
  parameter int START_TIMEOUT = 16,
  parameter int GAP_CYCLES    = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  pkt_tx_if.master                 bus,
  output logic                     busy,
  output logic [$clog2(N_SRC)-1:0] cur_src,
  output logic                     timeout_err,
  output logic [7:0]               drop_count
);
  localparam int IW = $clog2(N_SRC);
  localparam int WW = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(START_TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, WAIT_START, WAIT_DONE, GAP} state_t;
  localparam state_t AFTER_PKT = (GAP_CYCLES == 0) ? IDLE : GAP;

  state_t          state, state_nxt;
  logic [IW-1:0]   rr_ptr, rr_nxt;
  logic [WW-1:0]   wait_cnt, wait_nxt;
  logic [GW-1:0]   gap_cnt, gap_nxt;
  logic [N_SRC-1:0] ack_nxt;
  logic [7:0]      data_nxt, drop_nxt;
  logic            valid_nxt, terr_nxt, busy_nxt;
  logic [IW-1:0]   cur_nxt;

  logic [7:0]      src_byte [N_SRC];
  logic            found;
  logic [IW-1:0]   winner;
  int              idx;

  always_comb begin
    for (int i = 0; i < N_SRC; i++) src_byte[i] = bus.src_data[8*i +: 8];
  end

  // Search starts one past the last winner so every pending source is served before a repeat.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int i = 1; i <= N_SRC; i++) begin
      idx = (int'(rr_ptr) + i) % N_SRC;
      if (!found && bus.src_req[IW'(idx)]) begin
        found  = 1'b1;
        winner = IW'(idx);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    rr_nxt    = rr_ptr;
    wait_nxt  = wait_cnt;
    gap_nxt   = gap_cnt;
    ack_nxt   = '0;
    valid_nxt = 1'b0;
    data_nxt  = bus.pkt_data;
    cur_nxt   = cur_src;
    terr_nxt  = 1'b0;
    drop_nxt  = drop_count;
    case (state)
      IDLE: begin
        if (enable && found) begin
          ack_nxt[winner] = 1'b1;
          valid_nxt       = 1'b1;
          data_nxt        = src_byte[winner];
          cur_nxt         = winner;
          rr_nxt          = winner;
          wait_nxt        = '0;
          state_nxt       = WAIT_START;
        end
      end
      WAIT_START: begin
        if (bus.pkt_active) begin
          state_nxt = WAIT_DONE;
        end else if (wait_cnt == WAIT_LAST) begin
          terr_nxt  = 1'b1;
          drop_nxt  = (drop_count == 8'hFF) ? drop_count : drop_count + 8'd1;
          gap_nxt   = '0;
          state_nxt = AFTER_PKT;
        end else begin
          wait_nxt = wait_cnt + WW'(1);
        end
      end
      WAIT_DONE: begin
        if (!bus.pkt_active) begin
          gap_nxt   = '0;
          state_nxt = AFTER_PKT;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) state_nxt = IDLE;
        else                     gap_nxt   = gap_cnt + GW'(1);
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      rr_ptr             <= IW'(N_SRC - 1);
      wait_cnt           <= '0;
      gap_cnt            <= '0;
      bus.src_ack        <= '0;
      bus.pkt_data       <= '0;
      bus.pkt_data_valid <= 1'b0;
      busy               <= 1'b0;
      cur_src            <= '0;
      timeout_err        <= 1'b0;
      drop_count         <= '0;
    end else begin
      state              <= state_nxt;
      rr_ptr             <= rr_nxt;
      wait_cnt           <= wait_nxt;
      gap_cnt            <= gap_nxt;
      bus.src_ack        <= ack_nxt;
      bus.pkt_data       <= data_nxt;
      bus.pkt_data_valid <= valid_nxt;
      busy               <= busy_nxt;
      cur_src            <= cur_nxt;
      timeout_err        <= terr_nxt;
      drop_count         <= drop_nxt;
    end
  end
endmodule

// File: tb/tb_pkt_tx_scheduler.sv
// Scoreboard bench for pkt_tx_scheduler with simple source and packetiser models.
`timescale 1ns/1ps
module tb_pkt_tx_scheduler;
  localparam int N_SRC         = 4;
  localparam int START_TIMEOUT = 16;
  localparam int GAP_CYCLES    = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       busy, timeout_err;
  logic [1:0] cur_src;
  logic [7:0] drop_count;

  pkt_tx_if #(.N_SRC(N_SRC)) bus ();

  pkt_tx_scheduler #(
    .N_SRC(N_SRC), .START_TIMEOUT(START_TIMEOUT), .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .bus(bus.master),
    .busy(busy), .cur_src(cur_src), .timeout_err(timeout_err), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct { int src; logic [7:0] data; } exp_t;
  exp_t       exp_q[$];
  exp_t       mon_e;
  int         n_chk = 0, n_fail = 0;
  int         cyc = 0;
  int         model_rr;
  logic [7:0] tb_byte [N_SRC];
  logic [N_SRC-1:0] hold = '0;
  int         ack_cnt [N_SRC];
  int         n_issue = 0;
  int         last_fall = -1;
  bit         gap_chk = 0;
  int         pkt_len = 4;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic load_bytes();
    for (int i = 0; i < N_SRC; i++) bus.src_data[8*i +: 8] = tb_byte[i];
  endtask

  // Reference round-robin: grant order for a request set, each source dropping after its ack.
  task automatic expect_all(input logic [N_SRC-1:0] req);
    logic [N_SRC-1:0] r;
    int w, c;
    exp_t e;
    r = req;
    while (r != '0) begin
      w = -1;
      for (int k = 1; k <= N_SRC; k++) begin
        c = (model_rr + k) % N_SRC;
        if (w < 0 && r[c]) w = c;
      end
      e.src = w;
      e.data = tb_byte[w];
      exp_q.push_back(e);
      r[w] = 1'b0;
      model_rr = w;
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int i = 0; i < N_SRC; i++)
      if (bus.src_ack[i] && !hold[i]) bus.src_req[i] = 1'b0;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < N_SRC; i++) if (bus.src_ack[i]) ack_cnt[i]++;
      check_val("ack_valid_match", 32'(bus.src_ack != '0), 32'(bus.pkt_data_valid));
      if (bus.pkt_data_valid) begin
        n_issue++;
        check_val("sb_has_entry", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check_val("pkt_data", bus.pkt_data, mon_e.data);
          check_val("src_ack", bus.src_ack, 32'(1 << mon_e.src));
          check_val("cur_src", cur_src, mon_e.src);
          if (gap_chk && last_fall >= 0)
            check_val("gap_latency", cyc - last_fall, GAP_CYCLES + 2);
        end
      end
    end
  end

  // Packetiser model: pkt_active rises two cycles after a valid pulse and lasts pkt_len cycles.
  always @(negedge clk) begin
    if (rst_n && bus.pkt_data_valid && pkt_len > 0) begin
      repeat (2) @(negedge clk);
      bus.pkt_active = 1'b1;
      repeat (pkt_len) @(negedge clk);
      bus.pkt_active = 1'b0;
      last_fall = cyc;
    end
  end

  task automatic do_reset();
    int t;
    rst_n = 1'b0;
    enable = 1'b0;
    bus.src_req = '0;
    hold = '0;
    gap_chk = 0;
    t = 0;
    while (bus.pkt_active === 1'b1 && t < 100) begin tick(); t++; end
    exp_q.delete();
    model_rr = N_SRC - 1;
    for (int i = 0; i < N_SRC; i++) ack_cnt[i] = 0;
    repeat (2) tick();
    last_fall = -1;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int t;
    t = 0;
    while ((busy || exp_q.size() != 0) && t < budget) begin tick(); t++; end
    check_val(tag, 32'(busy), 0);
    check_val("sb_empty", exp_q.size(), 0);
  endtask

  initial begin
    int cnt, base;
    bus.src_req = '0;
    bus.src_data = '0;
    bus.pkt_active = 1'b0;
    #2;
    check_val("rst_busy", 32'(busy), 0);
    check_val("rst_valid", 32'(bus.pkt_data_valid), 0);
    check_val("rst_ack", bus.src_ack, 0);
    check_val("rst_data", bus.pkt_data, 0);
    check_val("rst_cur_src", cur_src, 0);
    check_val("rst_drop", drop_count, 0);
    check_val("rst_terr", 32'(timeout_err), 0);

    // single source, latency and busy tail
    do_reset();
    enable = 1'b1;
    pkt_len = 4;
    tb_byte[2] = 8'hAB;
    load_bytes();
    expect_all(4'b0100);
    bus.src_req = 4'b0100;
    tick();
    check_val("t1_valid_latency", 32'(bus.pkt_data_valid), 1);
    check_val("t1_busy", 32'(busy), 1);
    cnt = 0;
    while (bus.pkt_active !== 1'b1 && cnt < 50) begin tick(); cnt++; end
    cnt = 0;
    while (bus.pkt_active === 1'b1 && cnt < 50) begin tick(); cnt++; end
    check_val("t1_pkt_fall_seen", 32'(bus.pkt_active), 0);
    tick();
    check_val("t1_busy_gap0", 32'(busy), 1);
    tick();
    check_val("t1_busy_gap1", 32'(busy), 1);
    tick();
    check_val("t1_busy_low", 32'(busy), 0);

    // all four sources, round-robin order and gap spacing
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < N_SRC; i++) tb_byte[i] = 8'h10 + 8'(i);
    load_bytes();
    expect_all(4'b1111);
    gap_chk = 1;
    bus.src_req = 4'b1111;
    wait_idle("t2_idle", 300);
    gap_chk = 0;
    for (int i = 0; i < N_SRC; i++) check_val("t2_ack_count", ack_cnt[i], 1);

    // start timeout with a silent packetiser
    do_reset();
    enable = 1'b1;
    pkt_len = 0;
    tb_byte[0] = 8'hC0;
    tb_byte[1] = 8'hC1;
    load_bytes();
    expect_all(4'b0011);
    bus.src_req = 4'b0011;
    tick();
    check_val("t3_valid", 32'(bus.pkt_data_valid), 1);
    for (int n = 1; n <= 2; n++) begin
      cnt = 0;
      do begin tick(); cnt++; end while (!timeout_err && cnt < 40);
      check_val("t3_timeout_delay", cnt, START_TIMEOUT);
      check_val("t3_drop_count", drop_count, n);
      if (n == 1) begin
        cnt = 0;
        do begin tick(); cnt++; end while (!bus.pkt_data_valid && cnt < 40);
        check_val("t3_regrant_delay", cnt, GAP_CYCLES + 1);
      end
    end
    wait_idle("t3_idle", 50);
    pkt_len = 4;

    // enable gating
    do_reset();
    bus.src_req = 4'b1111;
    base = n_issue;
    repeat (50) tick();
    check_val("t4_no_issue", n_issue - base, 0);
    check_val("t4_not_busy", 32'(busy), 0);
    expect_all(4'b0001);
    enable = 1'b1;
    tick();
    check_val("t4_valid", 32'(bus.pkt_data_valid), 1);
    enable = 1'b0;
    wait_idle("t4_busy_fall", 50);
    check_val("t4_pkt_completed", 32'(last_fall >= 0), 1);
    base = n_issue;
    repeat (20) tick();
    check_val("t4_no_regrant", n_issue - base, 0);
    bus.src_req = '0;

    // asynchronous reset in WAIT_DONE
    do_reset();
    enable = 1'b1;
    pkt_len = 30;
    tb_byte[1] = 8'h5A;
    load_bytes();
    expect_all(4'b0010);
    bus.src_req = 4'b0010;
    cnt = 0;
    while (bus.pkt_active !== 1'b1 && cnt < 50) begin tick(); cnt++; end
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_val("t5_busy", 32'(busy), 0);
    check_val("t5_data", bus.pkt_data, 0);
    check_val("t5_cur_src", cur_src, 0);
    check_val("t5_valid", 32'(bus.pkt_data_valid), 0);
    check_val("t5_ack", bus.src_ack, 0);
    cnt = 0;
    while (bus.pkt_active === 1'b1 && cnt < 60) begin tick(); cnt++; end
    check_val("sb_empty", exp_q.size(), 0);
    pkt_len = 3;
    model_rr = N_SRC - 1;
    last_fall = -1;
    for (int i = 0; i < N_SRC; i++) tb_byte[i] = 8'h20 + 8'(i);
    load_bytes();
    expect_all(4'b1111);
    bus.src_req = 4'b1111;
    tick();
    rst_n = 1'b1;
    wait_idle("t5_idle", 300);

    // drop_count saturation
    do_reset();
    enable = 1'b1;
    pkt_len = 0;
    hold[0] = 1'b1;
    tb_byte[0] = 8'h66;
    load_bytes();
    for (int n = 0; n < 300; n++) expect_all(4'b0001);
    bus.src_req = 4'b0001;
    base = n_issue;
    for (int n = 1; n <= 300; n++) begin
      cnt = 0;
      do begin tick(); cnt++; end while (!timeout_err && cnt < 60);
      if (!timeout_err) begin
        check_val("t6_timeout_seen", 32'(timeout_err), 1);
        break;
      end
      if (n == 100) check_val("t6_drop_100", drop_count, 100);
      if (n == 255) check_val("t6_drop_255", drop_count, 255);
      if (n == 256) check_val("t6_drop_sat", drop_count, 255);
      if (n == 300) check_val("t6_drop_300", drop_count, 255);
    end
    hold = '0;
    bus.src_req = '0;
    wait_idle("t6_idle", 60);
    check_val("t6_issues", n_issue - base, 300);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
